// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-bounded arbiter sharing one FIFO write port
// Grants one producer at a time; writes are registered one cycle after each accept.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16
) (
  input  logic                      i_wr_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_rst_busy,
  input  logic                      i_almost_full,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_fifo_wr_en,
  output logic [DATA_W-1:0]         o_fifo_wr_data,
  output logic                      o_burst_done
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_gidx;
  logic [IDX_W-1:0]   r_last_grant;
  logic [7:0]         r_beat_cnt;
  logic               r_wr_en;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_burst_done;

  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W-1:0]   w_cand;
  logic               w_open;
  logic               w_g_valid;
  logic [DATA_W-1:0]  w_g_data;
  logic               w_accept;
  logic               w_release;

  assign w_open    = !i_almost_full && !i_wr_rst_busy;
  assign w_g_valid = i_req_valid[r_gidx];
  assign w_g_data  = i_req_data[r_gidx*DATA_W +: DATA_W];
  assign w_accept  = (r_state == ST_BURST) && w_g_valid && w_open;

  // grant is one-hot, so gating it by the accept condition yields the ready vector
  assign o_req_ready = w_accept ? r_grant : '0;

  // almost_full with no data is a pause, not a release
  assign w_release = (r_state == ST_BURST) &&
                     (i_wr_rst_busy ||
                      (!w_g_valid && !i_almost_full) ||
                      (w_accept && (r_beat_cnt == LAST_BEAT)));

  // Scan downward so the candidate closest after last_grant wins.
  always_comb begin
    w_pick_idx = r_last_grant;
    w_cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (i_req_valid[w_cand]) begin
        w_pick_idx = w_cand;
      end
    end
  end

  always_ff @(posedge i_wr_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_gidx       <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_wr_en      <= w_accept;
      r_burst_done <= w_release;
      if (w_accept) begin
        r_wr_data  <= w_g_data;
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_open && |i_req_valid) begin
            r_grant    <= NUM_REQ'(1) << w_pick_idx;
            r_gidx     <= w_pick_idx;
            r_beat_cnt <= '0;
            r_state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_release) begin
            r_grant      <= '0;
            r_last_grant <= r_gidx;
            r_beat_cnt   <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_grant        = r_grant;
  assign o_fifo_wr_en   = r_wr_en;
  assign o_fifo_wr_data = r_wr_data;
  assign o_burst_done   = r_burst_done;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed scoreboard bench for fifo_wr_arbiter
// Producers push expected beats on accept; the write monitor pops and compares.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_wr_rst_busy;
  logic        i_almost_full;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [3:0]  o_req_ready;
  logic [3:0]  o_grant;
  logic        o_fifo_wr_en;
  logic [7:0]  o_fifo_wr_data;
  logic        o_burst_done;

  int          checks = 0;
  int          failures = 0;
  int          bd_cnt = 0;
  int          burst_writes = 0;
  int          idle_len = 0;
  logic [7:0]  cnt [4];
  int          acc_cnt [4];
  logic [7:0]  last_wr_data = 8'h00;
  logic [7:0]  exp_q [$];
  int          burst_q [$];
  logic [3:0]  gq [$];
  int          gapq [$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_LEN(16)) dut (
    .i_wr_clk       (clk),
    .i_rst          (i_rst),
    .i_wr_rst_busy  (i_wr_rst_busy),
    .i_almost_full  (i_almost_full),
    .i_req_valid    (i_req_valid),
    .i_req_data     (i_req_data),
    .o_req_ready    (o_req_ready),
    .o_grant        (o_grant),
    .o_fifo_wr_en   (o_fifo_wr_en),
    .o_fifo_wr_data (o_fifo_wr_data),
    .o_burst_done   (o_burst_done)
  );

  function automatic logic [7:0] data_of(input int i, input logic [7:0] c);
    return {2'(i), c[5:0]};
  endfunction

  always_comb begin
    i_req_data = '0;
    for (int i = 0; i < 4; i++) i_req_data[i*8 +: 8] = data_of(i, cnt[i]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] acc;
    logic [3:0] pg;
    logic       rst_e;
    @(negedge clk);
    check("ready", 32'(o_req_ready),
          32'(o_grant & i_req_valid & {4{~i_almost_full & ~i_wr_rst_busy}}));
    rst_e = i_rst;
    acc   = rst_e ? 4'b0000 : (i_req_valid & o_req_ready);
    pg    = o_grant;
    for (int i = 0; i < 4; i++) if (acc[i]) exp_q.push_back(data_of(i, cnt[i]));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) begin
      cnt[i] = cnt[i] + 8'd1;
      acc_cnt[i]++;
    end
    check("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
    check("wr_en", 32'(o_fifo_wr_en), 32'(|acc));
    if (rst_e) begin
      check("rst_grant", 32'(o_grant), 32'd0);
      check("rst_wr_data", 32'(o_fifo_wr_data), 32'd0);
      check("rst_burst_done", 32'(o_burst_done), 32'd0);
      last_wr_data = 8'h00;
      burst_writes = 0;
      exp_q.delete();
    end else begin
      check("burst_done", 32'(o_burst_done), 32'(pg != 4'd0 && o_grant == 4'd0));
      if (o_fifo_wr_en) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("wr_data", 32'(o_fifo_wr_data), 32'(exp_q.pop_front()));
        last_wr_data = o_fifo_wr_data;
        burst_writes++;
      end else begin
        check("wr_data_hold", 32'(o_fifo_wr_data), 32'(last_wr_data));
      end
      if (o_burst_done) begin
        burst_q.push_back(burst_writes);
        burst_writes = 0;
        bd_cnt++;
      end
    end
    if (o_grant != 4'd0 && pg == 4'd0) begin
      gq.push_back(o_grant);
      gapq.push_back(idle_len);
      idle_len = 0;
    end else if (o_grant == 4'd0) begin
      idle_len++;
    end
  endtask

  task automatic run_until_bd(input int target, input int limit, input string tag);
    int k = 0;
    while (bd_cnt < target && k < limit) begin
      tick();
      k++;
    end
    check(tag, 32'(bd_cnt >= target), 32'd1);
  endtask

  task automatic run_until_acc(input int idx, input int target, input int limit, input string tag);
    int k = 0;
    while (acc_cnt[idx] < target && k < limit) begin
      tick();
      k++;
    end
    check(tag, 32'(acc_cnt[idx] >= target), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_order [5];
    int         gbase;
    int         a0;
    int         bd0;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      cnt[i]     = 8'd0;
      acc_cnt[i] = 0;
    end
    i_rst = 1'b1;
    i_wr_rst_busy = 1'b0;
    i_almost_full = 1'b0;
    i_req_valid = 4'b0000;

    // reset state
    tick();
    tick();
    i_rst = 1'b0;
    check("reset_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("reset_ready", 32'(o_req_ready), 32'd0);

    // 1: single requester, full burst, bubble, regrant continuing the stream
    i_req_valid = 4'b0001;
    tick();
    check("t1_grant", 32'(o_grant), 32'b0001);
    run_until_bd(bd_cnt + 1, 40, "t1_bd_timeout");
    check("t1_burst_len", 32'(burst_q[$]), 32'd16);
    check("t1_bubble_grant", 32'(o_grant), 32'd0);
    tick();
    check("t1_regrant", 32'(o_grant), 32'b0001);
    tick();
    check("t1_cont_en", 32'(o_fifo_wr_en), 32'd1);
    check("t1_cont_data", 32'(o_fifo_wr_data), 32'd16);
    i_req_valid = 4'b0000;
    tick();
    check("t1_drop_release", 32'(o_burst_done), 32'd1);
    tick();

    // 2: all requesters, round-robin from requester 0 after reset
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    gbase = gq.size();
    i_req_valid = 4'b1111;
    bd0 = bd_cnt;
    run_until_bd(bd0 + 5, 120, "t2_bd_timeout");
    i_req_valid = 4'b0000;
    check("t2_grant_count", 32'(gq.size() >= gbase + 5), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("t2_order", 32'(gq[gbase + k]), 32'(exp_order[k]));
      check("t2_burst_len", 32'(burst_q[burst_q.size() - 5 + k]), 32'd16);
      if (k > 0) check("t2_bubble", 32'(gapq[gbase + k]), 32'd1);
    end
    tick();
    tick();

    // 3: almost_full pause after the 5th accept
    i_req_valid = 4'b0001;
    tick();
    check("t3_grant", 32'(o_grant), 32'b0001);
    a0 = acc_cnt[0];
    run_until_acc(0, a0 + 5, 20, "t3_acc_timeout");
    i_almost_full = 1'b1;
    #1;
    check("t3_ready_drop", 32'(o_req_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_pause_wr_en", 32'(o_fifo_wr_en), 32'd0);
      check("t3_pause_grant", 32'(o_grant), 32'b0001);
    end
    i_almost_full = 1'b0;
    run_until_bd(bd_cnt + 1, 40, "t3_bd_timeout");
    check("t3_burst_len", 32'(burst_q[$]), 32'd16);
    check("t3_total_acc", 32'(acc_cnt[0] - a0), 32'd16);

    // 4: requester 1 runs dry after 3 beats, requester 2 follows
    i_req_valid = 4'b0110;
    tick();
    check("t4_grant1", 32'(o_grant), 32'b0010);
    a0 = acc_cnt[1];
    run_until_acc(1, a0 + 3, 20, "t4_acc_timeout");
    i_req_valid = 4'b0100;
    tick();
    check("t4_release", 32'(o_burst_done), 32'd1);
    check("t4_grant_idle", 32'(o_grant), 32'd0);
    check("t4_burst_len", 32'(burst_q[$]), 32'd3);
    tick();
    check("t4_grant2", 32'(o_grant), 32'b0100);

    // 5: wr_rst_busy aborts at beat 7
    i_req_valid = 4'b1101;
    a0 = acc_cnt[2];
    run_until_acc(2, a0 + 7, 20, "t5_acc_timeout");
    i_wr_rst_busy = 1'b1;
    #1;
    check("t5_ready_drop", 32'(o_req_ready), 32'd0);
    tick();
    check("t5_abort_done", 32'(o_burst_done), 32'd1);
    check("t5_abort_grant", 32'(o_grant), 32'd0);
    check("t5_abort_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("t5_burst_len", 32'(burst_q[$]), 32'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_busy_grant", 32'(o_grant), 32'd0);
    end
    i_wr_rst_busy = 1'b0;
    tick();
    check("t5_next_grant", 32'(o_grant), 32'b1000);

    // 6: reset mid-burst, then requester 0 wins first
    i_req_valid = 4'b1111;
    tick();
    tick();
    check("t6_in_burst", 32'(o_grant), 32'b1000);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("t6_rst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    tick();
    check("t6_first_grant", 32'(o_grant), 32'b0001);
    i_req_valid = 4'b0000;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 8-bit FIFO between NUM_REQ independent producers.
- Uses round-robin arbitration with bounded bursts.
- Honours the FIFO's almost_full and wr_rst_busy status.
- Sits between producer blocks and the FIFO write side, entirely in the wr_clk domain, and drives fifo_wr_en/fifo_wr_data registered.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width per requester and FIFO write width.
- BURST_LEN, 16, maximum beats accepted per grant (1..255).

Ports:
- wr_clk  input  1  write-domain clock.
- rst  input  1  synchronous reset, active-high.
- wr_rst_busy  input  1  FIFO write-side reset in progress; no writes allowed.
- almost_full  input  1  FIFO almost-full flag.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester accept (combinational).
- grant  output  NUM_REQ  one-hot current owner, registered; zero when idle.
- fifo_wr_en  output  1  FIFO write enable, registered.
- fifo_wr_data  output  DATA_W  FIFO write data, registered.
- burst_done  output  1  one-cycle pulse when a grant is released for any reason.

Behaviour:
- Interface: one clock, wr_clk; reset rst is synchronous, active-high. All state changes occur on the wr_clk rising edge.
- Reset values:
  - grant=0, fifo_wr_en=0, fifo_wr_data=0, burst_done=0.
  - state=IDLE, beat_cnt=0, last_grant=NUM_REQ-1, so requester 0 wins first.
  - Reset asserted mid-burst takes priority over everything; all outputs return to reset values at the next edge.
- States: IDLE, BURST.
- IDLE:
  - req_ready=0.
  - If !wr_rst_busy and !almost_full and |req_valid: pick the first valid requester searching from (last_grant+1) mod NUM_REQ upward with wrap. Load grant one-hot, beat_cnt=0, go to BURST. Grant latency: 1 cycle after the request is seen.
  - Otherwise stay in IDLE.
- BURST, granted index g:
  - req_ready[g] = req_valid[g] & !almost_full & !wr_rst_busy. All other ready bits are 0.
  - Accept is req_valid[g] & req_ready[g]. On accept:
    - next cycle fifo_wr_en=1 and fifo_wr_data=req_data[g];
    - beat_cnt+1.
    - Write latency is exactly 1 cycle after accept.
  - With no accept, fifo_wr_en=0 next cycle; fifo_wr_data holds its last value.
  - almost_full high: pause only. Stay in BURST and keep the grant. At most one write, accepted the previous cycle, completes after almost_full rises; the FIFO's almost-full margin covers it.
  - Release to IDLE on any of these, whichever comes first:
    - (a) the accept that makes beat_cnt = BURST_LEN;
    - (b) req_valid[g]=0 while !almost_full, meaning the requester has no data;
    - (c) wr_rst_busy=1, which aborts the burst.
  - On release: grant=0, last_grant=g, burst_done=1 for one cycle, beat_cnt=0.
  - The last beat and release occur in the same cycle. A new grant needs one IDLE cycle, so there is exactly one bubble between bursts.
- wr_rst_busy forces fifo_wr_en=0 at the next edge even if BURST is in progress.
- beat_cnt is 8 bits and never wraps; it is compared against BURST_LEN.
- A requester with no valid data is skipped. If only one requester is valid, it is regranted after each bubble.

Test Plan:
1. BURST_LEN=16; req_valid=4'b0001; req_data[0] counts 0,1,2… on accept.
   -> grant=0001 one cycle after request; fifo_wr_en high 16 cycles with data 0..15; burst_done pulse; one idle cycle; regrant 0001; data continues at 16.
2. req_valid=4'b1111, all held.
   -> grant order 0001, 0010, 0100, 1000, 0001; 16 writes each; one bubble between bursts; no beats lost or duplicated.
3. Single requester; almost_full high for 4 cycles after the 5th accept.
   -> req_ready drops the same cycle; fifo_wr_en low for 4 cycles (after the in-flight 5th write); grant held; burst resumes and totals 16 writes.
4. Requester 1 granted; req_valid[1] drops after 3 accepts while requester 2 is valid.
   -> 3 writes; burst_done pulse; grant 0100 two cycles later.
5. wr_rst_busy asserted at beat 7.
   -> burst aborts; fifo_wr_en 0 from the next edge; no grant while busy; after deassertion the next requester in round-robin order is granted.
6. rst pulsed mid-burst.
   -> at the next edge all outputs are 0 and state is IDLE; first grant after reset goes to requester 0 when all requesters are valid.
